// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Brief   : Shared constants and write-validity check for the clock divider.
// Revision: 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int c_default_div = 100;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int default_high(input int div);
        return div / 2;
    endfunction

    // Arguments are widened to 64 bits by the caller so one function serves any WIDTH.
    function automatic logic wr_valid(input logic [63:0] ch,
                                      input logic [63:0] channels,
                                      input logic [63:0] div,
                                      input logic [63:0] high);
        return (ch < channels) && (div >= 64'd2) && (high >= 64'd1) && (high < div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_if.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_if
// Brief   : Run-request, configuration-write and divided-clock output bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    localparam int CH_W = ch_width(CHANNELS);

    logic [CHANNELS-1:0] enable;
    logic                wrEn;
    logic [CH_W-1:0]     wrChannel;
    logic [WIDTH-1:0]    wrDivisor;
    logic [WIDTH-1:0]    wrHigh;
    logic                wrError;
    logic [CHANNELS-1:0] clkOut;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] running;

    modport master (
        output enable, wrEn, wrChannel, wrDivisor, wrHigh,
        input  wrError, clkOut, tick, running
    );

    modport slave (
        input  enable, wrEn, wrChannel, wrDivisor, wrHigh,
        output wrError, clkOut, tick, running
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_channel
// Brief   : One divided-clock channel: counter, active/pending config, run control.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = c_default_div
) (
    input  wire logic             clkIn,
    input  wire logic             reset,
    input  wire logic             enable,
    input  wire logic             wr_load,
    input  wire logic [WIDTH-1:0] wr_div,
    input  wire logic [WIDTH-1:0] wr_high,
    output logic                  clk_out,
    output logic                  tick,
    output logic                  running
);

    localparam logic [WIDTH-1:0] c_rst_div  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_rst_high = WIDTH'(default_high(DEFAULT_DIV));

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic [WIDTH-1:0] pend_high_q, pend_high_d;
    logic             pend_q, pend_d;
    logic             running_q, running_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             w_wrap;
    logic             w_apply;

    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        high_d      = high_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        pend_d      = pend_q;
        running_d   = running_q;

        w_wrap  = running_q && (cnt_q == (div_q - WIDTH'(1)));
        w_apply = pend_q && (w_wrap || !running_q);

        if (running_q) begin
            if (w_wrap) begin
                // Stop requests take effect only here, so a period is never cut short.
                cnt_d     = '0;
                running_d = enable;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (enable) begin
            running_d = 1'b1;
            cnt_d     = '0;
        end

        if (w_apply) begin
            div_d  = pend_div_q;
            high_d = pend_high_q;
            pend_d = 1'b0;
        end

        // A write landing on the wrap edge queues behind the values applied there.
        if (wr_load) begin
            pend_div_d  = wr_div;
            pend_high_d = wr_high;
            pend_d      = 1'b1;
        end

        clk_out_d = running_d && (cnt_d >= (div_d - high_d));
        tick_d    = running_d && (cnt_d == '0);
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            cnt_q       <= '0;
            div_q       <= c_rst_div;
            high_q      <= c_rst_high;
            pend_div_q  <= c_rst_div;
            pend_high_q <= c_rst_high;
            pend_q      <= 1'b0;
            running_q   <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            high_q      <= high_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            pend_q      <= pend_d;
            running_q   <= running_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign running = running_q;

endmodule
`default_nettype wire

// File: rtl/prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module  : prog_clk_divider
// Brief   : Multi-channel programmable clock divider: write decode and channel array.
// Revision: 1.0 - initial release
// ============================================================================
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = c_default_div
) (
    input  wire logic clkIn,
    input  wire logic reset,
    clk_div_if.slave  bus
);

    localparam int c_ch_w = ch_width(CHANNELS);

    logic w_wr_ok;
    logic wr_error_q, wr_error_d;

    always_comb begin
        w_wr_ok    = wr_valid(64'(bus.wrChannel), 64'(CHANNELS),
                              64'(bus.wrDivisor), 64'(bus.wrHigh));
        wr_error_d = bus.wrEn && !w_wr_ok;
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            wr_error_q <= 1'b0;
        end else begin
            wr_error_q <= wr_error_d;
        end
    end

    assign bus.wrError = wr_error_q;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            logic w_load;

            assign w_load = bus.wrEn && w_wr_ok && (bus.wrChannel == c_ch_w'(i));

            clk_div_channel #(
                .WIDTH       (WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .clkIn   (clkIn),
                .reset   (reset),
                .enable  (bus.enable[i]),
                .wr_load (w_load),
                .wr_div  (bus.wrDivisor),
                .wr_high (bus.wrHigh),
                .clk_out (bus.clkOut[i]),
                .tick    (bus.tick[i]),
                .running (bus.running[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_clk_divider
// Brief   : Scoreboard bench: per-cycle reference model vs. divided-clock outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_clk_divider;

    localparam int CH  = 3;
    localparam int W   = 16;
    localparam int DEF = 100;

    typedef struct packed {
        logic [CH-1:0] clk;
        logic [CH-1:0] tck;
        logic [CH-1:0] run;
        logic          err;
    } exp_t;

    logic clkIn = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    exp_t exp_q[$];

    int mcnt [CH];
    int md   [CH];
    int mh   [CH];
    int mpd  [CH];
    int mph  [CH];
    bit mpend[CH];
    bit mrun [CH];
    bit merr;

    clk_div_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    prog_clk_divider #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clkIn (clkIn),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkIn = ~clkIn;

    // Reference model: each channel is a period of D cycles whose last H cycles are high.
    always @(posedge clkIn) begin : model
        exp_t e;
        bit   ok;
        bit   wr;
        cycle++;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                mcnt[c] = 0; md[c] = DEF; mh[c] = DEF / 2;
                mpend[c] = 0; mrun[c] = 0;
            end
            merr = 0;
        end else begin
            ok = (int'(bus.wrChannel) < CH) && (int'(bus.wrDivisor) >= 2) &&
                 (int'(bus.wrHigh) >= 1) && (int'(bus.wrHigh) < int'(bus.wrDivisor));
            merr = bus.wrEn && !ok;
            for (int c = 0; c < CH; c++) begin
                wr = bus.wrEn && ok && (int'(bus.wrChannel) == c);
                if (mrun[c]) begin
                    if (mcnt[c] == md[c] - 1) begin
                        if (mpend[c]) begin md[c] = mpd[c]; mh[c] = mph[c]; mpend[c] = 0; end
                        mcnt[c] = 0;
                        mrun[c] = bus.enable[c];
                    end else begin
                        mcnt[c] = mcnt[c] + 1;
                    end
                end else begin
                    if (mpend[c]) begin md[c] = mpd[c]; mh[c] = mph[c]; mpend[c] = 0; end
                    if (bus.enable[c]) begin mrun[c] = 1; mcnt[c] = 0; end
                end
                if (wr) begin
                    mpd[c] = int'(bus.wrDivisor); mph[c] = int'(bus.wrHigh); mpend[c] = 1;
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            e.clk[c] = mrun[c] && (mcnt[c] >= md[c] - mh[c]);
            e.tck[c] = mrun[c] && (mcnt[c] == 0);
            e.run[c] = mrun[c];
        end
        e.err = merr;
        exp_q.push_back(e);
    end

    always @(negedge clkIn) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard cycle %0d: no expected entry queued", cycle);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.clkOut !== e.clk || bus.tick !== e.tck ||
                bus.running !== e.run || bus.wrError !== e.err) begin
                errors++;
                $display("FAIL outputs cycle %0d: got clkOut=%b tick=%b running=%b wrError=%b, required clkOut=%b tick=%b running=%b wrError=%b",
                         cycle, bus.clkOut, bus.tick, bus.running, bus.wrError,
                         e.clk, e.tck, e.run, e.err);
            end
        end
    end

    task automatic do_write(input int ch, input int d, input int h);
        bus.wrEn      = 1'b1;
        bus.wrChannel = 2'(ch);
        bus.wrDivisor = W'(d);
        bus.wrHigh    = W'(h);
        @(negedge clkIn);
        bus.wrEn      = 1'b0;
    endtask

    task automatic wait_cnt(input int ch, input int val);
        for (int n = 0; n < 400; n++) begin
            if (mrun[ch] && mcnt[ch] == val) return;
            @(negedge clkIn);
        end
        checks++;
        errors++;
        $display("FAIL wait_cnt ch%0d: count %0d not reached within 400 cycles", ch, val);
    endtask

    task automatic wait_idle(input int ch);
        for (int n = 0; n < 400; n++) begin
            if (!mrun[ch]) return;
            @(negedge clkIn);
        end
        checks++;
        errors++;
        $display("FAIL wait_idle ch%0d: channel still running after 400 cycles", ch);
    endtask

    // Measures low/high lengths of one full period on the DUT, tick to tick.
    task automatic measure_period(input int ch, input int el, input int eh);
        int lo;
        int hi;
        bit seen;
        seen = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clkIn);
            if (bus.tick[ch]) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL period ch%0d: no tick within 400 cycles", ch);
            return;
        end
        lo = 0; hi = 0; seen = 0;
        for (int n = 0; n < 400; n++) begin
            if (bus.clkOut[ch]) hi++; else lo++;
            @(negedge clkIn);
            if (bus.tick[ch]) begin seen = 1; break; end
        end
        checks++;
        if (!seen || lo != el || hi != eh) begin
            errors++;
            $display("FAIL period ch%0d: got low=%0d high=%0d closed=%0d, required low=%0d high=%0d",
                     ch, lo, hi, seen, el, eh);
        end
    endtask

    initial begin : stimulus
        int d;
        int h;
        reset         = 1'b1;
        bus.enable    = '0;
        bus.wrEn      = 1'b0;
        bus.wrChannel = '0;
        bus.wrDivisor = '0;
        bus.wrHigh    = '0;
        repeat (3) @(negedge clkIn);
        reset = 1'b0;
        @(negedge clkIn);

        // Defaults on channel 0.
        bus.enable[0] = 1'b1;
        measure_period(0, 50, 50);
        measure_period(0, 50, 50);

        // Idle write then start on channel 1.
        do_write(1, 5, 2);
        bus.enable[1] = 1'b1;
        measure_period(1, 3, 2);

        // Mid-period reconfiguration of channel 0.
        wait_cnt(0, 30);
        do_write(0, 10, 5);
        measure_period(0, 5, 5);
        do_write(0, 7, 3);
        do_write(0, 100, 50);
        measure_period(0, 50, 50);

        // Rejected writes.
        do_write(0, 1, 1);
        @(negedge clkIn);
        do_write(1, 8, 8);
        @(negedge clkIn);
        do_write(CH, 6, 3);
        @(negedge clkIn);
        do_write(2, 0, 0);
        repeat (20) @(negedge clkIn);

        // Stop at cnt 60, then a cancelled stop.
        wait_cnt(0, 60);
        bus.enable[0] = 1'b0;
        wait_idle(0);
        repeat (5) @(negedge clkIn);
        bus.enable[0] = 1'b1;
        wait_cnt(0, 60);
        bus.enable[0] = 1'b0;
        wait_cnt(0, 80);
        bus.enable[0] = 1'b1;
        measure_period(0, 50, 50);

        // Reset pulse in the high phase, with a write presented during reset.
        wait_cnt(0, 70);
        reset = 1'b1;
        do_write(2, 4, 1);
        reset = 1'b0;
        measure_period(0, 50, 50);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) begin
                d = $urandom_range(0, CH - 1);
                bus.enable[d] = ~bus.enable[d];
            end
            if ($urandom_range(0, 7) == 0) begin
                d = $urandom_range(0, 24);
                h = $urandom_range(0, d + 1);
                bus.wrEn      = 1'b1;
                bus.wrChannel = 2'($urandom_range(0, 3));
                bus.wrDivisor = W'(d);
                bus.wrHigh    = W'(h);
            end else begin
                bus.wrEn = 1'b0;
            end
            @(negedge clkIn);
        end
        reset    = 1'b0;
        bus.wrEn = 1'b0;
        repeat (50) @(negedge clkIn);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divided-clock outputs, range 1..16.
REQ-002 Parameter WIDTH, default 16: width of the divisor, high-time and per-channel counter.
REQ-003 Parameter DEFAULT_DIV, default 100: divisor loaded at reset, with high time DEFAULT_DIV/2; it must be 2 or more.
REQ-004 clkIn  in  1  sole clock; all logic is on the rising edge.
REQ-005 reset  in  1  reset, synchronous and active-high.
REQ-006 enable  in  CHANNELS  per-channel run request, level-sensitive.
REQ-007 wrEn  in  1  single-cycle configuration write strobe; it is always accepted.
REQ-008 wrChannel  in  max(1,clog2(CHANNELS))  target channel of the write.
REQ-009 wrDivisor  in  WIDTH  requested period, in clkIn cycles.
REQ-010 wrHigh  in  WIDTH  requested high time, in clkIn cycles.
REQ-011 wrError  out  1  registered one-cycle pulse when a write is rejected.
REQ-012 clkOut  out  CHANNELS  divided clocks, each driven directly from a flop.
REQ-013 tick  out  CHANNELS  registered one-cycle pulse at the start of each period.
REQ-014 running  out  CHANNELS  high while the channel is producing periods.

Function
REQ-015 Each channel holds an active divisor D, an active high time H, a counter cnt, a pending {D,H} register and a pending flag.
REQ-016 A running channel counts cnt 0..D-1; at cnt==D-1 the next value is 0 (wrap).
REQ-017 clkOut[i] is 1 exactly when running and cnt >= D-H; it is 0 otherwise.
REQ-018 The output period is exactly D cycles, with H high cycles at the end of the period and no runt pulses.
REQ-019 tick[i] is 1 in every cycle where running and cnt==0.
REQ-020 A write is valid iff wrChannel < CHANNELS, wrDivisor >= 2, and 1 <= wrHigh <= wrDivisor-1.
REQ-021 A valid write loads the channel's pending register and sets its pending flag.
REQ-022 A second valid write before the pending values are applied overwrites them (last write wins).
REQ-023 An invalid write changes no state and pulses wrError in the next cycle.
REQ-024 For a running channel, pending values transfer to D/H only at the wrap edge, so the new period starts at cnt 0.
REQ-025 For an idle channel, pending values transfer on the next edge.
REQ-026 A write and a wrap in the same cycle: the wrap applies the previously pending values; the new write becomes pending for the following wrap.
REQ-027 Start: when enable[i] rises while idle, running is set on the next edge with cnt=0, so tick fires in that cycle.
REQ-028 Stop: when enable[i] falls, the channel completes its current period; at the wrap edge it clears running and holds cnt=0 with clkOut low.
REQ-029 If enable[i] returns high before that wrap, the stop is cancelled with no gap in the output.
REQ-030 Channels are fully independent; a write to one channel has no effect on any other.

Reset
REQ-031 While reset is high at a clock edge, every channel takes: cnt=0, D=DEFAULT_DIV, H=DEFAULT_DIV/2, pending cleared, running=0, clkOut=0, tick=0; wrError=0.
REQ-032 Reset asserted mid-period aborts that period immediately, with no completion.
REQ-033 Writes presented during reset are ignored.
REQ-034 After reset releases, a channel with enable high starts per REQ-027.

Structure
REQ-035 A shared package clk_div_pkg holds the write-validity function and the reset-default constants.
REQ-036 Sub-module clk_div_channel implements one channel: counter, active/pending registers, start/stop control and the output flops.
REQ-037 The top level instantiates clk_div_channel CHANNELS times with a generate loop and contains only write decode, validation and the wrError flop.

Verification
REQ-038 Reset, then enable[0]=1 with defaults -> clkOut[0] low 50 cycles, high 50 cycles, repeating; tick every 100 cycles.
REQ-039 Write ch1 D=5 H=2 while idle, then enable -> period 5: low 3 cycles, high 2 cycles; first tick on the first running cycle.
REQ-040 Ch0 running at D=100; write D=10 H=5 at cnt=30 -> current 100-cycle period completes intact; next period is 10 cycles.
REQ-041 Write D=1; write D=8 H=8; write wrChannel=CHANNELS (CHANNELS<16) -> wrError pulses once for each, and all channel state is unchanged.
REQ-042 Drop enable at cnt=60 of a D=100 period -> output stays high through cnt=99, then low with running=0; a re-enable at cnt=80 instead leaves the waveform continuous.
REQ-043 Assert reset for 1 cycle mid-high-phase -> clkOut low and tick low next cycle; running restarts from cnt 0 at DEFAULT_DIV.
